motor_sequencer: RTL and testbench

Parametrised successor of the keypad-to-motor path. It buffers up to DEPTH decoded key codes, each selecting one of N_MOT motor channels. On `enter` it plays the buffer back, driving one one-hot motor output for STEP_CYCLES cycles followed by GAP_CYCLES cycles with all outputs off. It adds loop-repeat, abort and clear behaviour. It sits between the keypad decoder and the motor drivers; the display block reads `count`, `idx` and `busy`.

---
 rtl/motor_if.sv | 31 +++
 rtl/motor_sequencer.sv | 146 ++++++++++++++
 tb/tb_motor_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_if.sv
// Keypad-side and display/motor-side signals of the motor sequencer, bundled as one port.
// The master modport is the keypad/controller side; the sequencer takes the slave modport.
interface motor_if #(
  parameter int unsigned N_MOT = 3,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic            key_valid;
  logic [3:0]      key_code;
  logic            enter;
  logic            abort;
  logic            repeat_en;
  logic [N_MOT-1:0] motores;
  logic            busy;
  logic [CntW-1:0] count;
  logic [IdxW-1:0] idx;
  logic            full;
  logic            err;

  modport master (
    output key_valid, key_code, enter, abort, repeat_en,
    input  motores, busy, count, idx, full, err
  );

  modport slave (
    input  key_valid, key_code, enter, abort, repeat_en,
    output motores, busy, count, idx, full, err
  );
endinterface

// File: rtl/motor_sequencer.sv
// Buffers decoded key codes and plays them back as timed one-hot motor pulses
// separated by all-off gaps, with repeat, abort and clear handling.
module motor_sequencer #(
  parameter int unsigned N_MOT       = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000
) (
  input logic    clk,
  input logic    reset,
  motor_if.slave bus
);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CodeW  = (N_MOT > 1) ? $clog2(N_MOT) : 1;
  localparam int unsigned TimMax = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int unsigned TimW   = $clog2(TimMax + 1);
  localparam logic [TimW-1:0]  StepLast = TimW'(STEP_CYCLES - 1);
  localparam logic [TimW-1:0]  GapLast  = TimW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [N_MOT-1:0] MotOne   = N_MOT'(1);
  localparam logic [3:0]       KeyClear = 4'hF;

  typedef enum logic [1:0] {StLoad, StOn, StGap} state_e;

  state_e           state_q, state_d;
  logic [TimW-1:0]  timer_q, timer_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CodeW-1:0] entry_q [DEPTH];
  logic [CodeW-1:0] entry_d [DEPTH];
  logic [N_MOT-1:0] motores_q, motores_d;
  logic             busy_q, busy_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             step_done;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    count_d   = count_q;
    entry_d   = entry_q;
    err_d     = 1'b0;
    step_done = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (bus.enter) begin
          // enter beats a simultaneous key; the key is dropped and flagged
          err_d = bus.key_valid || (count_q == '0);
          if (count_q != '0) begin
            idx_d   = '0;
            timer_d = '0;
            state_d = StOn;
          end
        end else if (bus.key_valid) begin
          if (bus.key_code == KeyClear) begin
            count_d = '0;
          end else if (32'(bus.key_code) < N_MOT && !full_q) begin
            entry_d[count_q[IdxW-1:0]] = bus.key_code[CodeW-1:0];
            count_d = count_q + CntW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StOn: begin
        if (timer_q == StepLast) begin
          timer_d = '0;
          if (GAP_CYCLES == 0) step_done = 1'b1;
          else                 state_d   = StGap;
        end else begin
          timer_d = timer_q + TimW'(1);
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d   = '0;
          step_done = 1'b1;
        end else begin
          timer_d = timer_q + TimW'(1);
        end
      end
      default: state_d = StLoad;
    endcase

    if (step_done) begin
      if (CntW'(idx_q) + CntW'(1) < count_q) begin
        idx_d   = idx_q + IdxW'(1);
        state_d = StOn;
      end else if (bus.repeat_en) begin
        idx_d   = '0;
        state_d = StOn;
      end else begin
        idx_d   = '0;
        count_d = '0;
        state_d = StLoad;
      end
    end

    if (state_q != StLoad && bus.abort) begin
      state_d = StLoad;
      timer_d = '0;
      idx_d   = '0;
      count_d = '0;
    end
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    motores_d = (state_d == StOn) ? (MotOne << entry_d[idx_d]) : '0;
    busy_d    = (state_d != StLoad);
    full_d    = (count_d == CntW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StLoad;
      timer_q   <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      entry_q   <= '{default: '0};
      motores_q <= '0;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      entry_q   <= entry_d;
      motores_q <= motores_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  assign bus.motores = motores_q;
  assign bus.busy    = busy_q;
  assign bus.count   = count_q;
  assign bus.idx     = idx_q;
  assign bus.full    = full_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_motor_sequencer.sv
// Self-checking bench for motor_sequencer: directed scenarios plus randomized load/playback
// rounds checked against a queue-based model of the buffer and the playback timeline.
module tb_motor_sequencer;
  localparam int unsigned NMot   = 3;
  localparam int unsigned Depth  = 4;
  localparam int unsigned Step   = 5;
  localparam int unsigned Gap    = 2;
  localparam int unsigned Period = Step + Gap;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_q[$];

  motor_if #(.N_MOT(NMot), .DEPTH(Depth)) bus ();

  motor_sequencer #(
    .N_MOT(NMot), .DEPTH(Depth), .STEP_CYCLES(Step), .GAP_CYCLES(Gap)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one key pulse and applies the buffer rules to the model.
  task automatic send_key(input int code, output bit exp_err);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    tick();
    bus.key_valid = 1'b0;
    exp_err = 1'b0;
    if (code == 15) model_q.delete();
    else if (code < NMot && model_q.size() < Depth) model_q.push_back(code);
    else exp_err = 1'b1;
  endtask

  task automatic pulse_enter();
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
  endtask

  // Expected outputs for cycle t after enter, one pass over model_q without repeat.
  function automatic bit exp_busy(int t);
    return t < model_q.size() * Period;
  endfunction
  function automatic logic [NMot-1:0] exp_mot(int t);
    if (!exp_busy(t) || (t % Period) >= Step) return '0;
    return NMot'(1) << model_q[t / Period];
  endfunction
  function automatic logic [1:0] exp_idx(int t);
    return exp_busy(t) ? 2'(t / Period) : 2'd0;
  endfunction
  function automatic logic [2:0] exp_cnt(int t);
    return exp_busy(t) ? 3'(model_q.size()) : 3'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_q.delete();
    n_checks++;
    if (bus.motores !== 3'b000 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got motores=%b busy=%b err=%b want 000/0/0",
               bus.motores, bus.busy, bus.err);
    end
    n_checks++;
    if (bus.count !== 3'd0 || bus.idx !== 2'd0 || bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d idx=%0d full=%b want 0/0/0",
               bus.count, bus.idx, bus.full);
    end
  endtask

  task automatic test_basic_playback();
    bit e;
    int n;
    for (int c = 0; c < 3; c++) begin
      send_key(c, e);
      n_checks++;
      if (bus.count !== 3'(model_q.size()) || bus.err !== e) begin
        n_fail++;
        $display("FAIL basic_load: got count=%0d err=%b want %0d/%b",
                 bus.count, bus.err, model_q.size(), e);
      end
    end
    pulse_enter();
    n = model_q.size() * Period;
    for (int t = 0; t <= n; t++) begin
      n_checks++;
      if (bus.motores !== exp_mot(t) || bus.busy !== exp_busy(t) || bus.idx !== exp_idx(t) ||
          bus.count !== exp_cnt(t)) begin
        n_fail++;
        $display("FAIL basic_play t=%0d: got mot=%b busy=%b idx=%0d cnt=%0d want %b/%b/%0d/%0d",
                 t, bus.motores, bus.busy, bus.idx, bus.count,
                 exp_mot(t), exp_busy(t), exp_idx(t), exp_cnt(t));
      end
      if (t < n) tick();
    end
    model_q.delete();
  endtask

  task automatic test_full();
    bit e;
    int codes[5] = '{0, 0, 1, 2, 1};
    for (int i = 0; i < 5; i++) begin
      send_key(codes[i], e);
      n_checks++;
      if (bus.count !== 3'(model_q.size()) || bus.err !== e ||
          bus.full !== (model_q.size() == Depth)) begin
        n_fail++;
        $display("FAIL full_key%0d: got count=%0d err=%b full=%b want %0d/%b/%b", i,
                 bus.count, bus.err, bus.full, model_q.size(), e, model_q.size() == Depth);
      end
    end
    send_key(15, e);
    n_checks++;
    if (bus.count !== 3'd0 || bus.err !== 1'b0 || bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_key: got count=%0d err=%b full=%b want 0/0/0",
               bus.count, bus.err, bus.full);
    end
  endtask

  task automatic test_bad_codes();
    bit e;
    int codes[2] = '{3, 7};
    foreach (codes[i]) begin
      send_key(codes[i], e);
      n_checks++;
      if (bus.err !== 1'b1 || bus.count !== 3'd0) begin
        n_fail++;
        $display("FAIL bad_code %0d: got err=%b count=%0d want 1/0", codes[i], bus.err, bus.count);
      end
    end
    tick();
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_one_cycle: got err=%b want 0", bus.err);
    end
    pulse_enter();
    n_checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.motores !== 3'b000) begin
      n_fail++;
      $display("FAIL empty_enter: got err=%b busy=%b mot=%b want 1/0/000",
               bus.err, bus.busy, bus.motores);
    end
  endtask

  task automatic test_repeat();
    bit e;
    int drop_t = 3 * Period + 2;
    int end_t  = 4 * Period;
    logic [2:0] want_m;
    send_key(2, e);
    bus.repeat_en = 1'b1;
    pulse_enter();
    for (int t = 0; t <= end_t + 1; t++) begin
      want_m = (t < end_t && (t % Period) < Step) ? 3'b100 : 3'b000;
      n_checks++;
      if (bus.motores !== want_m || bus.busy !== (t < end_t)) begin
        n_fail++;
        $display("FAIL repeat t=%0d: got mot=%b busy=%b want %b/%b",
                 t, bus.motores, bus.busy, want_m, t < end_t);
      end
      if (t == drop_t) bus.repeat_en = 1'b0;
      tick();
    end
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL repeat_end_count: got %0d want 0", bus.count);
    end
    model_q.delete();
  endtask

  task automatic test_abort_and_reset();
    bit e;
    send_key(0, e);
    send_key(1, e);
    pulse_enter();
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.motores !== 3'b000 || bus.busy !== 1'b0 || bus.count !== 3'd0 || bus.idx !== 2'd0) begin
      n_fail++;
      $display("FAIL abort: got mot=%b busy=%b count=%0d idx=%0d want 000/0/0/0",
               bus.motores, bus.busy, bus.count, bus.idx);
    end
    model_q.delete();
    send_key(0, e);
    send_key(1, e);
    pulse_enter();
    for (int t = 0; t < Step; t++) tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.motores !== 3'b000) begin
      n_fail++;
      $display("FAIL pre_reset_gap: got busy=%b mot=%b want 1/000", bus.busy, bus.motores);
    end
    reset = 1'b1;
    bus.abort = 1'b1;
    tick();
    reset = 1'b0;
    bus.abort = 1'b0;
    n_checks++;
    if (bus.motores !== 3'b000 || bus.busy !== 1'b0 || bus.count !== 3'd0 || bus.idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_gap: got mot=%b busy=%b count=%0d idx=%0d want 000/0/0/0",
               bus.motores, bus.busy, bus.count, bus.idx);
    end
    model_q.delete();
  endtask

  task automatic test_key_with_enter();
    bit e;
    int n;
    send_key(2, e);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd1;
    bus.enter     = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.enter     = 1'b0;
    n_checks++;
    if (bus.err !== 1'b1 || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL key_enter_err: got err=%b count=%0d want 1/1", bus.err, bus.count);
    end
    n = model_q.size() * Period;
    for (int t = 0; t <= n; t++) begin
      n_checks++;
      if (bus.motores !== exp_mot(t) || bus.busy !== exp_busy(t) || (t > 0 && bus.err !== 1'b0))
      begin
        n_fail++;
        $display("FAIL key_enter_play t=%0d: got mot=%b busy=%b err=%b want %b/%b/0",
                 t, bus.motores, bus.busy, bus.err, exp_mot(t), exp_busy(t));
      end
      if (t < n) tick();
    end
    model_q.delete();
  endtask

  task automatic test_random();
    bit e;
    int code;
    int n;
    for (int round = 0; round < 20; round++) begin
      for (int k = $urandom_range(0, 6); k > 0; k--) begin
        code = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
        send_key(code, e);
        n_checks++;
        if (bus.count !== 3'(model_q.size()) || bus.err !== e ||
            bus.full !== (model_q.size() == Depth)) begin
          n_fail++;
          $display("FAIL rand_key %0d: got count=%0d err=%b full=%b want %0d/%b/%b", code,
                   bus.count, bus.err, bus.full, model_q.size(), e, model_q.size() == Depth);
        end
      end
      pulse_enter();
      n_checks++;
      if (bus.err !== (model_q.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_enter_err: got %b want %b", bus.err, model_q.size() == 0);
      end
      n = model_q.size() * Period;
      for (int t = 0; t <= n; t++) begin
        n_checks++;
        if (bus.motores !== exp_mot(t) || bus.busy !== exp_busy(t) || bus.idx !== exp_idx(t) ||
            bus.count !== exp_cnt(t) || (t > 0 && bus.err !== 1'b0)) begin
          n_fail++;
          $display("FAIL rand_play t=%0d: got mot=%b busy=%b idx=%0d cnt=%0d err=%b want %b/%b/%0d/%0d/0",
                   t, bus.motores, bus.busy, bus.idx, bus.count, bus.err,
                   exp_mot(t), exp_busy(t), exp_idx(t), exp_cnt(t));
        end
        if (t < n) begin
          bus.key_valid = 1'($urandom_range(0, 1));
          bus.key_code  = 4'($urandom_range(0, 15));
          bus.enter     = 1'($urandom_range(0, 3) == 0);
          tick();
          bus.key_valid = 1'b0;
          bus.enter     = 1'b0;
        end
      end
      model_q.delete();
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.enter     = 1'b0;
    bus.abort     = 1'b0;
    bus.repeat_en = 1'b0;
    test_reset();
    test_basic_playback();
    test_full();
    test_bad_codes();
    test_repeat();
    test_abort_and_reset();
    test_key_with_enter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
